// File: rtl/uart_tx_device.sv
// uart_tx_device: memory-mapped 8N1 serial transmitter, holding register plus shift register.
// Defining UART_TX_PARITY_EN inserts an even parity bit between the data bits and the stop bit.
module uart_tx_device #(
  parameter int               WBITS        = 32,
  parameter int               DBITS        = 8,
  parameter int               CBITS        = 5,
  parameter logic [WBITS-1:0] BASE         = WBITS'(32'hF0000040),
  parameter int               CLKS_PER_BIT = 130
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [WBITS-1:0] ABUS,
  inout  wire  [WBITS-1:0] DBUS,
  input  logic             WE,
  output logic             INTR,
  output logic             TXD
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW = (DBITS > 1) ? $clog2(DBITS) : 1;
  localparam logic [CW-1:0]    BAUD_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0]    BIT_LAST  = BW'(DBITS - 1);
  localparam logic [WBITS-1:0] ADDR_DATA = BASE;
  localparam logic [WBITS-1:0] ADDR_CTRL = BASE + WBITS'(4);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_e;
`else
  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;
`endif

  state_e           state_q, state_d;
  logic [CW-1:0]    baud_q, baud_d;
  logic [BW-1:0]    bit_q, bit_d;
  logic [DBITS-1:0] shift_q, shift_d;
  logic [DBITS-1:0] hold_q, hold_d;
  logic             ready_q, ready_d;
  logic             ovr_q, ovr_d;
  logic             rsv_q, rsv_d;
  logic             ie_q, ie_d;
  logic             txd_q, txd_d;

  logic             sel_data, sel_ctrl, wr_data, wr_ctrl, rd_en;
  logic             busy, baud_end, load;
  logic [CBITS-1:0] ctrl_rd;
  logic [WBITS-1:0] rdata;

  assign sel_data = (ABUS == ADDR_DATA);
  assign sel_ctrl = (ABUS == ADDR_CTRL);
  assign wr_data  = WE && sel_data;
  assign wr_ctrl  = WE && sel_ctrl;
  assign rd_en    = !WE && (sel_data || sel_ctrl);

  assign busy     = (state_q != S_IDLE);
  assign baud_end = (baud_q == BAUD_LAST);
  assign ctrl_rd  = {ie_q, rsv_q, busy, ovr_q, ready_q};
  assign rdata    = sel_ctrl ? {{(WBITS-CBITS){1'b0}}, ctrl_rd}
                             : {{(WBITS-DBITS){1'b0}}, hold_q};
  assign DBUS     = rd_en ? rdata : {WBITS{1'bz}};

  assign INTR = ready_q && ie_q;
  assign TXD  = txd_q;

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    hold_d  = hold_q;
    ready_d = ready_q;
    ovr_d   = ovr_q;
    rsv_d   = rsv_q;
    ie_d    = ie_q;
    load    = 1'b0;

    if (state_q == S_IDLE || baud_end) baud_d = '0;
    else                               baud_d = baud_q + CW'(1);

    case (state_q)
      S_IDLE:  load = !ready_q;
      S_START: if (baud_end) begin
        state_d = S_DATA;
        bit_d   = '0;
      end
      S_DATA: if (baud_end) begin
        if (bit_q == BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
          state_d = S_PARITY;
`else
          state_d = S_STOP;
`endif
        end else begin
          bit_d = bit_q + BW'(1);
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: if (baud_end) state_d = S_STOP;
`endif
      S_STOP: if (baud_end) begin
        if (!ready_q) load    = 1'b1;
        else          state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // A pending byte moves straight into the shifter; STOP chains into START with no gap.
    if (load) begin
      shift_d = hold_q;
      ready_d = 1'b1;
      state_d = S_START;
    end

    // Decisions use pre-edge READY, so a write that coincides with a transfer is an overrun.
    if (wr_data) begin
      if (ready_q) begin
        hold_d  = DBUS[DBITS-1:0];
        ready_d = 1'b0;
      end else begin
        ovr_d = 1'b1;
      end
    end

    if (wr_ctrl) begin
      ie_d  = DBUS[4];
      rsv_d = DBUS[3];
      ovr_d = DBUS[1] & ovr_q;
    end
  end

  always_comb begin
    txd_d = 1'b1;
    case (state_d)
      S_START:  txd_d = 1'b0;
      S_DATA:   txd_d = shift_d[bit_d];
`ifdef UART_TX_PARITY_EN
      S_PARITY: txd_d = ^shift_d;
`endif
      default:  txd_d = 1'b1;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      hold_q  <= '0;
      ready_q <= 1'b1;
      ovr_q   <= 1'b0;
      rsv_q   <= 1'b0;
      ie_q    <= 1'b0;
      txd_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      hold_q  <= hold_d;
      ready_q <= ready_d;
      ovr_q   <= ovr_d;
      rsv_q   <= rsv_d;
      ie_q    <= ie_d;
      txd_q   <= txd_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_device.sv
// tb_uart_tx_device: frame-timing reference model plus directed scenarios for uart_tx_device.
module tb_uart_tx_device;

  localparam int          CPB    = 4;
  localparam logic [31:0] A_DATA = 32'hF0000040;
  localparam logic [31:0] A_CTRL = 32'hF0000044;
  localparam int          LOGN   = 4096;
`ifdef UART_TX_PARITY_EN
  localparam int NB        = 11;
  localparam int FRAME_CYC = 44;
`else
  localparam int NB        = 10;
  localparam int FRAME_CYC = 40;
`endif
  localparam int FRAME = NB * CPB;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic [31:0] ABUS = A_CTRL;
  logic        WE = 1'b0;
  logic [31:0] tb_d = 32'd0;
  logic        tb_oe = 1'b0;
  wire  [31:0] DBUS;
  logic        INTR;
  logic        TXD;

  assign DBUS = tb_oe ? tb_d : 32'bz;

  uart_tx_device #(.CLKS_PER_BIT(CPB)) dut (
    .CLK  (CLK),
    .RESET(RESET),
    .ABUS (ABUS),
    .DBUS (DBUS),
    .WE   (WE),
    .INTR (INTR),
    .TXD  (TXD)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  logic chk_en = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a byte queue of depth one plus a frame timer counting cycles into the frame.
  logic       m_ready = 1'b1, m_ovr = 1'b0, m_ie = 1'b0, m_rsv = 1'b0, m_active = 1'b0;
  logic [7:0] m_hold = 8'd0, m_byte = 8'd0;
  int         m_t = 0;

  always @(posedge CLK or negedge RESET) begin : model
    logic nready;
    logic ld;
    if (!RESET) begin
      m_ready = 1'b1; m_ovr = 1'b0; m_ie = 1'b0; m_rsv = 1'b0;
      m_active = 1'b0; m_hold = 8'd0; m_t = 0;
    end else begin
      nready = m_ready;
      ld = 1'b0;
      if (!m_active) ld = !m_ready;
      else if (m_t == FRAME - 1) begin
        if (!m_ready) ld = 1'b1;
        else          m_active = 1'b0;
      end else m_t = m_t + 1;
      if (ld) begin
        m_active = 1'b1; m_t = 0; m_byte = m_hold; nready = 1'b1;
      end
      if (WE && ABUS == A_DATA) begin
        if (m_ready) begin m_hold = tb_d[7:0]; nready = 1'b0; end
        else m_ovr = 1'b1;
      end
      if (WE && ABUS == A_CTRL) begin
        m_ie = tb_d[4]; m_rsv = tb_d[3]; m_ovr = tb_d[1] & m_ovr;
      end
      m_ready = nready;
    end
  end

  function automatic logic exp_txd();
    int idx;
    if (!m_active) return 1'b1;
    idx = m_t / CPB;
    if (idx == 0) return 1'b0;
    if (idx <= 8) return m_byte[3'(idx - 1)];
`ifdef UART_TX_PARITY_EN
    if (idx == 9) return ^m_byte;
`endif
    return 1'b1;
  endfunction

  int   cyc = 0;
  logic txd_log [LOGN];
  logic busy_log[LOGN];
  logic vld_log [LOGN];

  always @(negedge CLK) begin
    if (chk_en) begin
      check("txd", 32'(TXD), 32'(exp_txd()));
      check("intr", 32'(INTR), 32'(m_ready & m_ie));
      if (!WE && ABUS == A_CTRL)
        check("ctrl_rd", DBUS, {27'd0, m_ie, m_rsv, m_active, m_ovr, m_ready});
      if (!WE && ABUS == A_DATA)
        check("data_rd", DBUS, {24'd0, m_hold});
    end
    if (cyc < LOGN) begin
      txd_log[cyc]  = TXD;
      vld_log[cyc]  = !WE && ABUS == A_CTRL;
      busy_log[cyc] = DBUS[2];
    end
    cyc++;
  end

  function automatic logic log_at(input int i);
    if (i < 0 || i >= LOGN || i >= cyc) return 1'b1;
    return txd_log[i];
  endfunction

  function automatic logic [7:0] decode(input int s);
    logic [7:0] b;
    for (int k = 0; k < 8; k++) b[k] = log_at(s + CPB * (k + 1) + CPB / 2);
    return b;
  endfunction

  function automatic int find_start(input int from);
    for (int i = from; i < cyc && i < LOGN; i++) if (txd_log[i] == 1'b0) return i;
    return -1;
  endfunction

  function automatic int busy_span(input int from);
    int first = -1;
    int last = -1;
    for (int i = from; i < cyc && i < LOGN; i++)
      if (vld_log[i] && busy_log[i]) begin
        if (first < 0) first = i;
        last = i;
      end
    return (first < 0) ? 0 : last - first + 1;
  endfunction

  task automatic set_write(input logic [31:0] a, input logic [31:0] d);
    @(posedge CLK); #1;
    ABUS = a; WE = 1'b1; tb_oe = 1'b1; tb_d = d;
  endtask

  task automatic set_read(input logic [31:0] a);
    @(posedge CLK); #1;
    ABUS = a; WE = 1'b0; tb_oe = 1'b0;
  endtask

  task automatic set_idle();
    set_read(A_CTRL);
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    do begin @(negedge CLK); n++; end
    while (!(DBUS[2] == 1'b0 && DBUS[0] == 1'b1) && n < 400);
    check({nm, "_idle_wait"}, 32'(n < 400), 32'd1);
  endtask

  task automatic wait_ready(input string nm);
    int n = 0;
    do begin @(negedge CLK); n++; end
    while (DBUS[0] != 1'b1 && n < 400);
    check({nm, "_ready_wait"}, 32'(n < 400), 32'd1);
  endtask

  task automatic check_frame(input string nm, input int s, input logic [7:0] b);
    check({nm, "_start_found"}, 32'(s >= 0), 32'd1);
    check({nm, "_byte"}, 32'(decode(s)), 32'(b));
    check({nm, "_stop"}, 32'(log_at(s + (NB - 1) * CPB + CPB / 2)), 32'd1);
  endtask

  initial begin
    int mark;
    int s;
    #2 RESET = 1'b0;
    #1 chk_en = 1'b1;
    repeat (3) @(posedge CLK);
    #1 RESET = 1'b1;
    @(negedge CLK);
    check("rst_ctrl", DBUS, 32'h0000_0001);
    check("rst_txd", 32'(TXD), 32'd1);
    check("rst_intr", 32'(INTR), 32'd0);

    // Reset asserted mid-frame with IE/RSV set must restore every reset value at once.
    set_write(A_CTRL, 32'h18);
    set_write(A_DATA, 32'h00);
    set_idle();
    repeat (10) @(negedge CLK);
    check("mid_txd_low", 32'(TXD), 32'd0);
    check("mid_intr", 32'(INTR), 32'd1);
    #2 RESET = 1'b0;
    #1;
    check("arst_txd", 32'(TXD), 32'd1);
    check("arst_ctrl", DBUS, 32'h0000_0001);
    check("arst_intr", 32'(INTR), 32'd0);
    @(posedge CLK); #1 RESET = 1'b1;
    repeat (2) @(negedge CLK);

    mark = cyc;
    set_write(A_DATA, 32'hA5);
    set_idle();
    @(negedge CLK);
    check("a5_ready_lo", 32'(DBUS[0]), 32'd0);
    @(negedge CLK);
    check("a5_ready_hi", 32'(DBUS[0]), 32'd1);
    wait_idle("a5");
    @(negedge CLK);
    s = find_start(mark);
    check_frame("a5", s, 8'hA5);
    check("a5_busy_cycles", 32'(busy_span(mark)), 32'(FRAME_CYC));

    mark = cyc;
    set_write(A_DATA, 32'h55);
    set_idle();
    wait_ready("b2b");
    set_write(A_DATA, 32'h0F);
    set_idle();
    wait_idle("b2b");
    @(negedge CLK);
    s = find_start(mark);
    check_frame("b2b_first", s, 8'h55);
    check_frame("b2b_second", s + FRAME_CYC, 8'h0F);
    check("b2b_busy_cycles", 32'(busy_span(mark)), 32'(2 * FRAME_CYC));
    check("b2b_ovr", 32'(DBUS[1]), 32'd0);

    // 8'h22 lands once READY is back; 8'h33 follows on the next cycle while the holding register is full.
    mark = cyc;
    set_write(A_DATA, 32'h11);
    set_idle();
    wait_ready("ovr");
    set_write(A_DATA, 32'h22);
    set_write(A_DATA, 32'h33);
    set_idle();
    @(negedge CLK);
    check("ovr_set", 32'(DBUS[1]), 32'd1);
    wait_idle("ovr");
    @(negedge CLK);
    check("ovr_sticky", 32'(DBUS[1]), 32'd1);
    s = find_start(mark);
    check_frame("ovr_first", s, 8'h11);
    check_frame("ovr_second", s + FRAME_CYC, 8'h22);
    check("ovr_busy_cycles", 32'(busy_span(mark)), 32'(2 * FRAME_CYC));
    set_read(A_DATA);
    @(negedge CLK);
    check("ovr_data_rd", DBUS, 32'h0000_0022);
    set_write(A_CTRL, 32'h0);
    set_idle();
    @(negedge CLK);
    check("ovr_clear", 32'(DBUS[1]), 32'd0);

    set_write(A_CTRL, 32'h10);
    set_idle();
    @(negedge CLK);
    check("intr_ie", 32'(INTR), 32'd1);
    set_write(A_DATA, 32'h3C);
    set_idle();
    @(negedge CLK);
    check("intr_drop", 32'(INTR), 32'd0);
    @(negedge CLK);
    check("intr_back", 32'(INTR), 32'd1);
    wait_idle("intr");
    set_write(A_CTRL, 32'h0);
    set_idle();
    @(negedge CLK);
    check("intr_off", 32'(INTR), 32'd0);

`ifdef UART_TX_PARITY_EN
    mark = cyc;
    set_write(A_DATA, 32'h07);
    set_idle();
    wait_idle("par07");
    @(negedge CLK);
    s = find_start(mark);
    check_frame("par07", s, 8'h07);
    check("par07_bit", 32'(log_at(s + 9 * CPB + CPB / 2)), 32'd1);
    check("par07_busy_cycles", 32'(busy_span(mark)), 32'd44);
    mark = cyc;
    set_write(A_DATA, 32'h03);
    set_idle();
    wait_idle("par03");
    @(negedge CLK);
    s = find_start(mark);
    check_frame("par03", s, 8'h03);
    check("par03_bit", 32'(log_at(s + 9 * CPB + CPB / 2)), 32'd0);
`endif

    repeat (2) @(negedge CLK);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout t=%0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
